// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
//
// Round-robin arbiter that shares the single read port of the sprite/palette
// memory between pixel-domain requesters (player mapper, enemy/boss mapper,
// background fetch). One read is granted per Clk. A tag pipeline follows each
// read through the fixed memory latency so the returned word is steered back
// to the requester that issued it.
//
// Ports:
//   Clk       pixel clock, single clock domain
//   Reset     synchronous, active-high reset
//   req       per-requester read request (level, held until granted)
//   addr      packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   gnt       one-hot grant, combinational from req in the same cycle
//   rvalid    one-hot, one-cycle pulse marking rdata for requester k
//   rdata     returned memory word, registered, shared by all requesters
//   mem_addr  address to sprite memory
//   mem_rden  memory read enable
//   mem_q     memory read data, valid RD_LAT cycles after mem_rden
//
// Handshake: a request is consumed at the Clk edge where gnt[k]=1; the
// requester may change addr or drop req in the following cycle. Dropping req
// before it is granted withdraws it with no side effects. There is no
// back-pressure on the return path: rvalid is a single-cycle pulse.

module sprite_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rden,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win;
    logic               found;
    logic [RD_LAT-1:0]  tag_v;
    logic [IDX_W-1:0]   tag_idx [RD_LAT];
    logic [NUM_REQ-1:0] ret_onehot;

    // Priority search: offset i visits index (ptr+i) mod NUM_REQ, so the
    // first asserted request at or after ptr wins. Reset masks the grant.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[k] && (k == (int'(ptr) + i) % NUM_REQ)) begin
                    found = 1'b1;
                    win   = IDX_W'(k);
                end
            end
        end
        if (Reset) begin
            found = 1'b0;
        end
    end

    always_comb begin
        gnt      = '0;
        mem_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (found && (win == IDX_W'(k))) begin
                gnt[k]   = 1'b1;
                mem_addr = addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign mem_rden = found;

    // Pointer moves just past the winner, so a requester holding req is
    // served again only after every other active requester had its turn.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + IDX_W'(1);
        end
    end

    // Tag pipeline: stage RD_LAT-1 lines up with mem_q for the read it names.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= found;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
        end
    end

    // Index stages carry no reset; they are only consulted alongside tag_v.
    always_ff @(posedge Clk) begin
        tag_idx[0] <= win;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_idx[i] <= tag_idx[i-1];
        end
    end

    always_comb begin
        ret_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ret_onehot[k] = tag_v[RD_LAT-1] && (tag_idx[RD_LAT-1] == IDX_W'(k));
        end
    end

    // rdata holds the last returned word between returns.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= ret_onehot;
            if (tag_v[RD_LAT-1]) begin
                rdata <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb_sprite_mem_arbiter
//
// Drives three arbiter configurations side by side: (NUM_REQ=3, RD_LAT=2)
// with directed scenarios followed by random traffic, and (NUM_REQ=2,
// RD_LAT=1) / (NUM_REQ=2, RD_LAT=4) with random traffic throughout. Each
// configuration has its own memory model whose word is a fixed function of
// the address. Expected grants and returns are queued when stimulus is
// issued; a monitor on the falling edge pops and compares.

module tb_sprite_mem_arbiter;

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] data;
    } ret_t;

    typedef struct {
        logic [2:0]  gnt;
        logic [15:0] addr;
    } gexp_t;

    logic        Clk = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        quiet = 1'b0;

    logic        rst_a   [3];
    logic [2:0]  req_a   [3];
    logic [47:0] addr_a  [3];
    logic [2:0]  gnt_a   [3];
    logic [2:0]  rv_a    [3];
    logic [7:0]  rdata_a [3];
    logic [15:0] maddr_a [3];
    logic        rden_a  [3];

    int          mptr    [3];
    logic [7:0]  last_rd [3];
    ret_t        ret_q   [3][$];
    gexp_t       gnt_q   [3][$];

    gexp_t       m_ge;
    ret_t        m_re;
    logic [2:0]  m_erv;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [7:0] hash(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h87;
    endfunction

    function automatic int nreq(input int g);
        return (g == 0) ? 3 : 2;
    endfunction

    function automatic int lat(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int N = (g == 0) ? 3 : 2;
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        logic [N-1:0]    req_l;
        logic [N-1:0]    gnt_l;
        logic [N-1:0]    rv_l;
        logic [N*16-1:0] addr_l;
        logic [15:0]     ma;
        logic            rd;
        logic [7:0]      rq;
        logic [7:0]      mq;
        logic [15:0]     mp [4];

        assign req_l      = req_a[g][N-1:0];
        assign addr_l     = addr_a[g][N*16-1:0];
        assign gnt_a[g]   = 3'(gnt_l);
        assign rv_a[g]    = 3'(rv_l);
        assign rdata_a[g] = rq;
        assign maddr_a[g] = ma;
        assign rden_a[g]  = rd;

        // Memory model: word for an address appears L cycles after it.
        always @(posedge Clk) begin
            mp[0] <= ma;
            for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
        end
        assign mq = hash(mp[L-1]);

        sprite_mem_arbiter #(
            .NUM_REQ(N), .ADDR_W(16), .DATA_W(8), .RD_LAT(L)
        ) dut (
            .Clk(Clk), .Reset(rst_a[g]), .req(req_l), .addr(addr_l),
            .gnt(gnt_l), .rvalid(rv_l), .rdata(rq),
            .mem_addr(ma), .mem_rden(rd), .mem_q(mq)
        );
    end

    task automatic check(input string name, input int g,
                         input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d cyc%0d: got %0h expected %0h",
                     name, g, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs to configuration g and record what the
    // round-robin rules say must happen this cycle and on the return path.
    task automatic drive(input int g, input logic rst,
                         input logic [2:0] r, input logic [47:0] a);
        int          n;
        int          w;
        logic [47:0] sh;
        gexp_t       ge;
        ret_t        re;
        n  = nreq(g);
        r  = r & 3'((1 << n) - 1);
        rst_a[g]  = rst;
        req_a[g]  = r;
        addr_a[g] = a;
        ge.gnt  = '0;
        ge.addr = '0;
        w = -1;
        if (rst) begin
            mptr[g] = 0;
            // Returns that would surface after the reset edge are lost.
            while (ret_q[g].size() > 0 && ret_q[g][ret_q[g].size()-1].due > cyc)
                ret_q[g].delete(ret_q[g].size() - 1);
        end else begin
            for (int i = 0; i < n; i++) begin
                int c;
                c = (mptr[g] + i) % n;
                if (w < 0 && r[c]) w = c;
            end
            if (w >= 0) begin
                sh = a >> (w * 16);
                ge.gnt[w] = 1'b1;
                ge.addr   = sh[15:0];
                mptr[g]   = (w + 1) % n;
                re.due  = cyc + lat(g) + 1;
                re.idx  = w;
                re.data = hash(sh[15:0]);
                ret_q[g].push_back(re);
            end
        end
        gnt_q[g].push_back(ge);
    endtask

    task automatic step(input logic rst0, input logic [2:0] r0, input logic [47:0] a0);
        @(posedge Clk);
        #1;
        drive(0, rst0, r0, a0);
        for (int g = 1; g < 3; g++) begin
            if (quiet)
                drive(g, rst0, 3'b000, rnd48());
            else
                drive(g, rst0 | ($urandom_range(0, 39) == 0),
                      3'($urandom_range(0, 7)), rnd48());
        end
    endtask

    // Monitor: every falling edge, compare each configuration against the
    // oldest expected grant and, if one is due, the oldest expected return.
    always @(negedge Clk) begin
        for (int g = 0; g < 3; g++) begin
            if (gnt_q[g].size() > 0) begin
                m_ge = gnt_q[g].pop_front();
                check("gnt", g, 48'(gnt_a[g]), 48'(m_ge.gnt));
                check("mem_rden", g, 48'(rden_a[g]), 48'(|m_ge.gnt));
                check("mem_addr", g, 48'(maddr_a[g]), 48'(m_ge.addr));
                check("rvalid_onehot0", g, 48'($onehot0(rv_a[g])), 48'd1);
                m_erv = '0;
                if (ret_q[g].size() > 0 && ret_q[g][0].due == cyc) begin
                    m_re = ret_q[g].pop_front();
                    m_erv[m_re.idx] = 1'b1;
                    last_rd[g] = m_re.data;
                end
                check("rvalid", g, 48'(rv_a[g]), 48'(m_erv));
                check("rdata", g, 48'(rdata_a[g]), 48'(last_rd[g]));
                if (rst_a[g]) last_rd[g] = 8'h00;
            end
        end
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_a[g]   = 1'b1;
            req_a[g]   = '0;
            addr_a[g]  = '0;
            mptr[g]    = 0;
            last_rd[g] = 8'h00;
        end

        step(1'b1, 3'b000, 48'h0);
        step(1'b1, 3'b000, 48'h0);

        // Single read from r1: word for 16'h0123 is 8'hA5.
        step(1'b0, 3'b010, 48'h0000_0123_0000);
        repeat (3) step(1'b0, 3'b000, 48'h0);

        // Full contention from a fresh pointer.
        step(1'b1, 3'b000, 48'h0);
        for (int i = 0; i < 9; i++)
            step(1'b0, 3'b111, {16'(16'h1000 + 3*i + 2), 16'(16'h1000 + 3*i + 1),
                                16'(16'h1000 + 3*i)});

        // Idle with junk addresses on the bus.
        repeat (10) step(1'b0, 3'b000, rnd48());

        // Rotation: r0 granted, then r2 beats r0, then r0.
        step(1'b0, 3'b001, rnd48());
        step(1'b0, 3'b101, rnd48());
        step(1'b0, 3'b101, rnd48());
        repeat (3) step(1'b0, 3'b000, rnd48());

        // Withdrawal: r1 drops req the cycle after r0 wins.
        step(1'b0, 3'b100, rnd48());
        step(1'b0, 3'b011, rnd48());
        step(1'b0, 3'b000, rnd48());
        repeat (4) step(1'b0, 3'b000, rnd48());

        // Reset while r2's read is in flight, then lowest index wins.
        step(1'b0, 3'b100, rnd48());
        step(1'b1, 3'b000, rnd48());
        step(1'b0, 3'b110, rnd48());
        repeat (4) step(1'b0, 3'b000, rnd48());

        // Random traffic on all configurations.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, 3'($urandom_range(0, 7)), rnd48());

        quiet = 1'b1;
        repeat (8) step(1'b0, 3'b000, 48'h0);
        @(negedge Clk);
        #1;
        for (int g = 0; g < 3; g++)
            check("drain", g, 48'(ret_q[g].size()), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_mem_arbiter.md
Name: sprite_mem_arbiter

Overview:
- Round-robin arbiter that shares the single read port of the on-chip sprite/palette memory between pixel-domain requesters: player_mapper, enemy/boss mapper and background fetch.
- Grants one read per Clk, issues the address to memory and tracks each in-flight read with a tag pipeline.
- Returns each memory word to the requester that issued it.
- Sits between the color-mapper blocks and the sprite ROM, clocked on the VGA pixel clock.

Parameters:
NUM_REQ, 3, number of requesters (legal 2..8)
ADDR_W, 16, sprite memory address width
DATA_W, 8, memory word width
RD_LAT, 2, fixed memory read latency in Clk cycles from address to mem_q (legal 1..4)

Ports:
Clk  input  1  pixel clock; single clock domain
Reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester read request, level; held until granted
addr  input  NUM_REQ*ADDR_W  packed addresses; requester k at bits [k*ADDR_W +: ADDR_W]
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as req
rvalid  output  NUM_REQ  one-hot, one-cycle pulse marking returned data for requester k
rdata  output  DATA_W  returned word, shared by all requesters, registered
mem_addr  output  ADDR_W  address to sprite memory
mem_rden  output  1  memory read enable
mem_q  input  DATA_W  memory read data, valid RD_LAT cycles after mem_rden

Behaviour:
- State:
  - ptr: log2(NUM_REQ)-bit priority pointer.
  - Tag pipeline: RD_LAT stages of {valid, idx}.
  - Output registers: rvalid, rdata.
- Reset (Reset=1 at a Clk edge):
  - ptr=0, all tag stages invalid, rvalid=0, rdata=0.
  - While Reset=1: gnt=0, mem_rden=0, mem_addr=0.
- Arbitration (combinational):
  - Search req starting at index ptr, ascending, wrapping modulo NUM_REQ. The first asserted index w wins.
  - gnt[w]=1, mem_rden=1, mem_addr=addr[w].
  - No req asserted: gnt=0, mem_rden=0, mem_addr=0.
- Handshake:
  - A request is consumed at the Clk edge where gnt[k]=1.
  - The requester may change addr or deassert req in the next cycle.
  - A requester holding req continuously gets one grant per turn.
  - Deasserting req before it is granted cancels it with no side effects.
- Pointer update:
  - On a grant to w: ptr <= (w+1) mod NUM_REQ.
  - No grant: ptr unchanged.
  - Worst-case wait for an asserted req is NUM_REQ-1 cycles.
- Tag pipeline:
  - Stage0 <= {mem_rden, w}; stage i <= stage i-1 each cycle; no stall.
  - Final stage aligns with mem_q.
- Return:
  - If the final stage is valid with index k: rvalid <= one-hot(k), rdata <= mem_q.
  - Otherwise rvalid <= 0 and rdata holds its previous value.
  - Total latency: grant in cycle T gives rvalid/rdata visible in cycle T+RD_LAT+1.
  - Throughput is 1 read/cycle; returns come back in grant order.
- Simultaneous events: multiple reqs in one cycle produce exactly one grant. A grant and a return in the same cycle are independent.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. The first grant after reset goes to the lowest-index asserted req.
- Invariants (assertion targets): gnt one-hot or zero; rvalid one-hot or zero; mem_rden == |gnt.

Test Plan:
- Single read: Reset, then req=3'b010, addr[1]=16'h0123, memory model returns 8'hA5 -> same cycle gnt=3'b010, mem_addr=16'h0123, mem_rden=1; 3 cycles later rvalid=3'b010, rdata=8'hA5; ptr=2.
- Full contention: req=3'b111 held for 9 cycles, distinct addrs -> grants 0,1,2,0,1,2,0,1,2; rvalid sequence identical, lagged 3 cycles; rdata matches each addr; no idle cycles.
- Rotation: after a grant to r0 (ptr=1), assert req=3'b101 -> gnt=3'b100 (r2 wins); next cycle gnt=3'b001.
- Reset mid-flight: grant r2 in cycle T, Reset=1 in cycle T+1 -> no rvalid in T+3 or later; after release, req=3'b110 -> gnt=3'b010.
- Idle and withdrawal: req=0 for 10 cycles -> gnt=0, mem_rden=0, mem_addr=0, rvalid=0, ptr unchanged. r1 withdrawn the same cycle r0 is granted -> r1 never granted and no rvalid[1].
- Parameter sweep: RD_LAT=1 and RD_LAT=4 with NUM_REQ=2 -> latency RD_LAT+1 holds; ordering and one-hot invariants hold.
